dispatch_alloc_ctrl: RTL and testbench

// Dispatch-width arbiter for the 2-wide out-of-order core. Sits between ID and fl/rob/rs.

---
 rtl/dispatch_alloc_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dispatch_alloc_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_alloc_ctrl
// Description : 2-wide dispatch grant from free-tag / ROB / RS credit, with
//               branch-mispredict recovery sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_alloc_ctrl #(
    parameter int NUM_PR         = 96,
    parameter int NUM_ARCH       = 32,
    parameter int ROB_SIZE       = 32,
    parameter int RS_SIZE        = 16,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  id_valid_num,
    input  logic [1:0]  rob_retire_num,
    input  logic [1:0]  rs_issue_num,
    input  logic        ex_mispredict,
    input  logic [5:0]  ex_squash_num,
    output logic [1:0]  id_dispatch_num,
    output logic        id_stall,
    output logic        recovering,
    output logic [15:0] stall_cycles,
    output logic        acct_err
);

    localparam int c_FREE_MAX = NUM_PR - NUM_ARCH;
    localparam int c_FREE_W   = $clog2(c_FREE_MAX + 1);
    localparam int c_ROB_W    = $clog2(ROB_SIZE + 1);
    localparam int c_RS_W     = $clog2(RS_SIZE + 1);
    localparam int c_REC_W    = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam int c_AW       = 12;

    localparam logic signed [c_AW-1:0] c_ZERO       = '0;
    localparam logic signed [c_AW-1:0] c_ONE        = c_AW'(1);
    localparam logic signed [c_AW-1:0] c_TWO        = c_AW'(2);
    localparam logic signed [c_AW-1:0] c_FREE_MAX_S = c_AW'(c_FREE_MAX);
    localparam logic signed [c_AW-1:0] c_ROB_MAX_S  = c_AW'(ROB_SIZE);
    localparam logic signed [c_AW-1:0] c_RS_MAX_S   = c_AW'(RS_SIZE);

    localparam logic [0:0] S_RUN     = 1'b0;
    localparam logic [0:0] S_RECOVER = 1'b1;

    logic [0:0]          r_state;
    logic [c_REC_W-1:0]  r_rec_cnt;
    logic [c_FREE_W-1:0] r_free_cnt;
    logic [c_ROB_W-1:0]  r_rob_cnt;
    logic [c_RS_W-1:0]   r_rs_cnt;
    logic [15:0]         r_stall_cycles;
    logic                r_acct_err;

    logic [1:0] w_req;
    logic [1:0] w_avail;
    logic [1:0] w_grant;
    logic       w_hold;
    logic       w_stall;
    logic       w_clamp;

    logic signed [c_AW-1:0] w_free_s, w_rob_s, w_rs_s;
    logic signed [c_AW-1:0] w_rob_room, w_rs_room;
    logic signed [c_AW-1:0] w_ret_s, w_iss_s, w_sq_s, w_gnt_s;
    logic signed [c_AW-1:0] w_free_nx, w_rob_nx, w_rs_nx;
    logic signed [c_AW-1:0] w_free_cl, w_rob_cl, w_rs_cl;

    function automatic logic signed [c_AW-1:0] f_clamp(
        input logic signed [c_AW-1:0] v,
        input logic signed [c_AW-1:0] hi
    );
        if (v < c_ZERO) return c_ZERO;
        if (v > hi)     return hi;
        return v;
    endfunction

    assign w_free_s   = c_AW'(r_free_cnt);
    assign w_rob_s    = c_AW'(r_rob_cnt);
    assign w_rs_s     = c_AW'(r_rs_cnt);
    assign w_rob_room = c_ROB_MAX_S - w_rob_s;
    assign w_rs_room  = c_RS_MAX_S - w_rs_s;
    assign w_ret_s    = c_AW'(rob_retire_num);
    assign w_iss_s    = c_AW'(rs_issue_num);
    assign w_sq_s     = c_AW'(ex_squash_num);
    assign w_gnt_s    = c_AW'(w_grant);

    // Grant sees only registered credit; this cycle's retire/issue land next cycle.
    always_comb begin
        w_req = (id_valid_num == 2'd3) ? 2'd2 : id_valid_num;
        if ((w_free_s >= c_TWO) && (w_rob_room >= c_TWO) && (w_rs_room >= c_TWO)) begin
            w_avail = 2'd2;
        end else if ((w_free_s >= c_ONE) && (w_rob_room >= c_ONE) && (w_rs_room >= c_ONE)) begin
            w_avail = 2'd1;
        end else begin
            w_avail = 2'd0;
        end
        w_hold  = reset | ex_mispredict | (r_state == S_RECOVER);
        w_grant = w_hold ? 2'd0 : ((w_req < w_avail) ? w_req : w_avail);
        w_stall = ~reset & (w_req > w_grant);
    end

    always_comb begin
        w_free_nx = w_free_s + w_ret_s - w_gnt_s;
        w_rob_nx  = w_rob_s + w_gnt_s - w_ret_s;
        w_rs_nx   = w_rs_s + w_gnt_s - w_iss_s;
        if (ex_mispredict) begin
            w_free_nx = w_free_s + w_ret_s + w_sq_s;
            w_rob_nx  = w_rob_s - w_ret_s - w_sq_s;
            w_rs_nx   = c_ZERO;
        end else if (r_state == S_RECOVER) begin
            w_free_nx = w_free_s + w_ret_s;
            w_rob_nx  = w_rob_s - w_ret_s;
            w_rs_nx   = c_ZERO;
        end
    end

    assign w_free_cl = f_clamp(w_free_nx, c_FREE_MAX_S);
    assign w_rob_cl  = f_clamp(w_rob_nx, c_ROB_MAX_S);
    assign w_rs_cl   = f_clamp(w_rs_nx, c_RS_MAX_S);

    // A clamped value, or one that would not fit its counter, is an accounting fault.
    assign w_clamp = (w_free_cl != w_free_nx) | (w_rob_cl != w_rob_nx) | (w_rs_cl != w_rs_nx)
                   | (|w_free_cl[c_AW-1:c_FREE_W]) | (|w_rob_cl[c_AW-1:c_ROB_W])
                   | (|w_rs_cl[c_AW-1:c_RS_W]);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_RUN;
            r_rec_cnt      <= '0;
            r_free_cnt     <= c_FREE_W'(c_FREE_MAX);
            r_rob_cnt      <= '0;
            r_rs_cnt       <= '0;
            r_stall_cycles <= '0;
            r_acct_err     <= 1'b0;
        end else begin
            r_free_cnt <= w_free_cl[c_FREE_W-1:0];
            r_rob_cnt  <= w_rob_cl[c_ROB_W-1:0];
            r_rs_cnt   <= w_rs_cl[c_RS_W-1:0];
            if (w_clamp) begin
                r_acct_err <= 1'b1;
            end
            if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (ex_mispredict) begin
                r_state   <= S_RECOVER;
                r_rec_cnt <= c_REC_W'(RECOVER_CYCLES - 1);
            end else if (r_state == S_RECOVER) begin
                if (r_rec_cnt == '0) begin
                    r_state <= S_RUN;
                end else begin
                    r_rec_cnt <= r_rec_cnt - c_REC_W'(1);
                end
            end
        end
    end

    assign id_dispatch_num = w_grant;
    assign id_stall        = w_stall;
    assign recovering      = (r_state == S_RECOVER);
    assign stall_cycles    = r_stall_cycles;
    assign acct_err        = r_acct_err;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_alloc_ctrl
// Description : Directed bench; two DUT copies (default, and a 16-tag pool)
//               checked every cycle against a credit-pool model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_alloc_ctrl;

    localparam int c_RC       = 2;
    localparam int c_ROB      = 32;
    localparam int c_RS       = 16;
    localparam int c_FMAX [2] = '{64, 16};

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  id_valid_num = '0;
    logic [1:0]  rob_retire_num = '0;
    logic [1:0]  rs_issue_num = '0;
    logic        ex_mispredict = 1'b0;
    logic [5:0]  ex_squash_num = '0;

    logic [1:0]  g_a, g_b;
    logic        st_a, st_b, rc_a, rc_b, er_a, er_b;
    logic [15:0] sc_a, sc_b;

    int total = 0;
    int bad   = 0;

    int m_free [2];
    int m_rob  [2];
    int m_rs   [2];
    int m_hold [2];
    int m_stall[2];
    int m_err  [2];
    bit m_valid = 1'b0;

    always #5 clock = ~clock;

    dispatch_alloc_ctrl u_dut_a (
        .clock(clock), .reset(reset), .id_valid_num(id_valid_num),
        .rob_retire_num(rob_retire_num), .rs_issue_num(rs_issue_num),
        .ex_mispredict(ex_mispredict), .ex_squash_num(ex_squash_num),
        .id_dispatch_num(g_a), .id_stall(st_a), .recovering(rc_a),
        .stall_cycles(sc_a), .acct_err(er_a)
    );

    dispatch_alloc_ctrl #(.NUM_PR(48)) u_dut_b (
        .clock(clock), .reset(reset), .id_valid_num(id_valid_num),
        .rob_retire_num(rob_retire_num), .rs_issue_num(rs_issue_num),
        .ex_mispredict(ex_mispredict), .ex_squash_num(ex_squash_num),
        .id_dispatch_num(g_b), .id_stall(st_b), .recovering(rc_b),
        .stall_cycles(sc_b), .acct_err(er_b)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_req();
        return (id_valid_num == 2'd3) ? 2 : int'(id_valid_num);
    endfunction

    function automatic int exp_grant(input int k);
        int g;
        if (m_hold[k] > 0 || ex_mispredict) return 0;
        g = exp_req();
        if (g > 2)               g = 2;
        if (g > m_free[k])       g = m_free[k];
        if (g > c_ROB - m_rob[k]) g = c_ROB - m_rob[k];
        if (g > c_RS - m_rs[k])  g = c_RS - m_rs[k];
        return (g < 0) ? 0 : g;
    endfunction

    function automatic int fit(input int v, input int hi, input int k);
        if (v < 0)  begin m_err[k] = 1; return 0;  end
        if (v > hi) begin m_err[k] = 1; return hi; end
        return v;
    endfunction

    // Credit-pool model: advances once per rising edge.
    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                for (int k = 0; k < 2; k++) begin
                    m_free[k] = c_FMAX[k]; m_rob[k] = 0; m_rs[k] = 0;
                    m_hold[k] = 0; m_stall[k] = 0; m_err[k] = 0;
                end
                m_valid = 1'b1;
            end else if (m_valid) begin
                for (int k = 0; k < 2; k++) begin
                    int g, f, r, s, ret, iss, sq;
                    g   = exp_grant(k);
                    ret = int'(rob_retire_num);
                    iss = int'(rs_issue_num);
                    sq  = int'(ex_squash_num);
                    if (exp_req() > g && m_stall[k] < 65535) m_stall[k]++;
                    if (ex_mispredict) begin
                        f = m_free[k] + ret + sq; r = m_rob[k] - ret - sq; s = 0;
                        m_hold[k] = c_RC;
                    end else if (m_hold[k] > 0) begin
                        f = m_free[k] + ret; r = m_rob[k] - ret; s = 0;
                        m_hold[k]--;
                    end else begin
                        f = m_free[k] + ret - g; r = m_rob[k] + g - ret; s = m_rs[k] + g - iss;
                    end
                    m_free[k] = fit(f, c_FMAX[k], k);
                    m_rob[k]  = fit(r, c_ROB, k);
                    m_rs[k]   = fit(s, c_RS, k);
                end
            end
        end
    end

    // Every-cycle comparison of both copies against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && m_valid) begin
                for (int k = 0; k < 2; k++) begin
                    int eg;
                    eg = exp_grant(k);
                    check(k == 0 ? "a_grant" : "b_grant", k == 0 ? int'(g_a) : int'(g_b), eg);
                    check(k == 0 ? "a_stall" : "b_stall", k == 0 ? int'(st_a) : int'(st_b),
                          (exp_req() > eg) ? 1 : 0);
                    check(k == 0 ? "a_recovering" : "b_recovering", k == 0 ? int'(rc_a) : int'(rc_b),
                          (m_hold[k] > 0) ? 1 : 0);
                    check(k == 0 ? "a_stall_cycles" : "b_stall_cycles",
                          k == 0 ? int'(sc_a) : int'(sc_b), m_stall[k]);
                    check(k == 0 ? "a_acct_err" : "b_acct_err", k == 0 ? int'(er_a) : int'(er_b),
                          m_err[k]);
                end
            end
        end
    end

    task automatic step(input int v, input int ret, input int iss, input int mp, input int sq);
        @(posedge clock);
        #1;
        reset          = 1'b0;
        id_valid_num   = 2'(v);
        rob_retire_num = 2'(ret);
        rs_issue_num   = 2'(iss);
        ex_mispredict  = mp[0];
        ex_squash_num  = 6'(sq);
        @(negedge clock);
    endtask

    // Holds reset over two edges and returns at a falling edge with reset still high.
    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        id_valid_num = '0; rob_retire_num = '0; rs_issue_num = '0;
        ex_mispredict = 1'b0; ex_squash_num = '0;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        do_reset();
        check("rst_grant", int'(g_a), 0);
        check("rst_recovering", int'(rc_a), 0);
        check("rst_stall_cycles", int'(sc_a), 0);
        check("rst_acct_err", int'(er_a), 0);

        // RS fills after eight double grants.
        for (int i = 0; i < 8; i++) begin
            step(2, 0, 0, 0, 0);
            check("t1_grant2", int'(g_a), 2);
        end
        step(2, 0, 0, 0, 0);
        check("t1_rs_full_grant", int'(g_a), 0);
        check("t1_rs_full_stall", int'(st_a), 1);
        step(0, 0, 0, 0, 0);
        check("t1_stall_cycles", int'(sc_a), 1);

        // ROB fills with RS continually drained; retire credit is not bypassed.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(2, 0, 2, 0, 0);
            check("t2_grant2", int'(g_a), 2);
        end
        step(2, 2, 0, 0, 0);
        check("t2_rob_full_grant", int'(g_a), 0);
        step(2, 0, 0, 0, 0);
        check("t2_after_retire_grant", int'(g_a), 2);
        check("t2_acct_err", int'(er_a), 0);

        // Tag exhaustion on the 16-tag copy.
        do_reset();
        for (int i = 0; i < 7; i++) step(2, 0, 2, 0, 0);
        step(1, 0, 1, 0, 0);
        check("t3_req1_grant", int'(g_b), 1);
        step(2, 0, 0, 0, 0);
        check("t3_free1_grant", int'(g_b), 1);
        step(2, 1, 0, 0, 0);
        check("t3_free0_grant", int'(g_b), 0);
        step(2, 0, 0, 0, 0);
        check("t3_retired_grant", int'(g_b), 1);

        // Mispredict with rob=10, rs=6, squash=7, retire=1.
        do_reset();
        for (int i = 0; i < 3; i++) step(2, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(2, 0, 2, 0, 0);
        step(2, 1, 0, 1, 7);
        check("t4_mp_grant", int'(g_a), 0);
        check("t4_mp_stall", int'(st_a), 1);
        step(2, 0, 0, 0, 0);
        check("t4_rec1", int'(rc_a), 1);
        check("t4_rec1_grant", int'(g_a), 0);
        step(2, 0, 0, 0, 0);
        check("t4_rec2", int'(rc_a), 1);
        step(2, 0, 0, 0, 0);
        check("t4_resume_rec", int'(rc_a), 0);
        check("t4_resume_grant", int'(g_a), 2);
        for (int i = 0; i < 7; i++) step(2, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0);
        check("t4_rs_flushed", int'(g_a), 0);

        // Second mispredict restarts the hold; oversize squash clamps the ROB.
        do_reset();
        for (int i = 0; i < 5; i++) step(2, 0, 0, 0, 0);
        step(2, 0, 0, 1, 3);
        step(2, 0, 0, 0, 0);
        step(2, 0, 0, 1, 20);
        check("t5_mp2_grant", int'(g_a), 0);
        step(2, 0, 0, 0, 0);
        check("t5_hold1", int'(rc_a), 1);
        check("t5_acct_err", int'(er_a), 1);
        step(2, 0, 0, 0, 0);
        check("t5_hold2", int'(rc_a), 1);
        check("t5_hold2_grant", int'(g_a), 0);
        step(2, 0, 0, 0, 0);
        check("t5_resume_grant", int'(g_a), 2);

        // Saturating stall counter, then reset in the middle of recovery.
        do_reset();
        for (int i = 0; i < 8; i++) step(2, 0, 0, 0, 0);
        for (int i = 0; i < 70000; i++) step(2, 0, 0, 0, 0);
        check("t6_sat", int'(sc_a), 16'hFFFF);
        step(2, 0, 0, 1, 1);
        step(2, 0, 0, 0, 0);
        check("t6_in_recover", int'(rc_a), 1);
        do_reset();
        check("t6_rst_rec", int'(rc_a), 0);
        check("t6_rst_sc", int'(sc_a), 0);
        check("t6_rst_err_b", int'(er_b), 0);
        check("t6_rst_grant", int'(g_a), 0);
        check("t6_rst_stall", int'(st_a), 0);
        step(2, 0, 0, 0, 0);
        check("t6_post_grant", int'(g_a), 2);
        check("t6_post_rec", int'(rc_a), 0);
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
